hello_nios2_qsys_oci_dct_packer: RTL and testbench

Packs 2-bit debug-trace atoms from the Nios II OCI trace path into 30-bit compressed trace frames. Presents each frame as `dct_buffer` with its fill level `dct_count`, plus end-of-test status (`test_ending`, `test_has_ended`), to the OCI test-bench stage directly downstream. Frames are held in a one-entry output slot under a valid/ready handshake. A flush request drains any partial frame and then signals test completion.

---
 rtl/hello_nios2_qsys_oci_dct_pkg.sv | 18 +
 rtl/hello_nios2_qsys_oci_dct_slot.sv | 32 +++
 rtl/hello_nios2_qsys_oci_dct_packer.sv | 112 +++++++++++
 tb/tb_hello_nios2_qsys_oci_dct_packer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hello_nios2_qsys_oci_dct_pkg.sv
// Shared definitions for the OCI debug-trace packer: atom/frame geometry,
// the no-op atom code and the packer state encoding.
package hello_nios2_qsys_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = ATOM_W * SLOTS;
  localparam int CNT_W  = 4;

  localparam logic [ATOM_W-1:0] ATOM_NOP = 2'b00;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/hello_nios2_qsys_oci_dct_slot.sv
// One-entry valid/ready holding register for a packed trace frame and its
// fill count; contents stay frozen while the frame waits to be consumed.
module hello_nios2_qsys_oci_dct_slot #(
  parameter int BUF_W = 30,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid <= 1'b0;
      dct_buffer  <= '0;
      dct_count   <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      dct_buffer  <= load_buffer;
      dct_count   <= load_count;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hello_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into 30-bit frames, hands them downstream through
// a one-entry slot, and drains the partial frame on an end-of-test flush.
module hello_nios2_qsys_oci_dct_packer #(
  parameter int ATOM_W = hello_nios2_qsys_oci_dct_pkg::ATOM_W,
  parameter int SLOTS  = hello_nios2_qsys_oci_dct_pkg::SLOTS,
  parameter int BUF_W  = ATOM_W * SLOTS,
  parameter int CNT_W  = hello_nios2_qsys_oci_dct_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              flush,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  import hello_nios2_qsys_oci_dct_pkg::*;

  dct_state_e       state;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;

  logic             slot_free;
  logic             full_now;
  logic             accept;
  logic             store;
  logic             transfer;
  logic [BUF_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // A full accumulator is never shifted: the incoming atom starts the next
  // frame instead, so the 15th atom of a frame can go straight to the slot.
  always_comb begin
    slot_free  = !frame_valid || frame_ready;
    full_now   = (acc_cnt == CNT_W'(SLOTS));
    atom_ready = !reset && (state == ACCUM) && !(full_now && !slot_free);
    accept     = atom_valid && atom_ready;
    store      = accept && (atom != ATOM_W'(ATOM_NOP));
    acc_nxt    = acc;
    cnt_nxt    = acc_cnt;
    if (store && !full_now) begin
      acc_nxt = {acc[BUF_W-ATOM_W-1:0], atom};
      cnt_nxt = acc_cnt + 1'b1;
    end
    transfer = slot_free &&
               ((cnt_nxt == CNT_W'(SLOTS)) || ((state == DRAIN) && (acc_cnt != '0)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (transfer) begin
      acc     <= (store && full_now) ? BUF_W'(atom) : '0;
      acc_cnt <= (store && full_now) ? CNT_W'(1) : '0;
    end else begin
      acc     <= acc_nxt;
      acc_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ACCUM;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (flush) begin
            state       <= DRAIN;
            test_ending <= 1'b1;
          end
        end
        DRAIN: begin
          if ((acc_cnt == '0) && slot_free) begin
            state          <= ENDED;
            test_has_ended <= 1'b1;
          end
        end
        ENDED: ;
        default: begin
          state          <= ACCUM;
          test_ending    <= 1'b0;
          test_has_ended <= 1'b0;
        end
      endcase
    end
  end

  hello_nios2_qsys_oci_dct_slot #(
    .BUF_W(BUF_W),
    .CNT_W(CNT_W)
  ) u_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (transfer),
    .load_buffer (acc_nxt),
    .load_count  (cnt_nxt),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

endmodule

// File: tb/tb_hello_nios2_qsys_oci_dct_packer.sv
// Directed bench for the OCI trace packer: framing, backpressure, flush/drain,
// coincident events and mid-drain reset, against hand-computed frames.
module tb_hello_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int n_chk  = 0;
  int n_fail = 0;

  hello_nios2_qsys_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0; frame_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_n;
    logic unstable;

    reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0; frame_ready = 1'b0;
    @(negedge clk);
    cyc();
    check("rst_atom_ready", atom_ready, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_buffer", dct_buffer, 0);
    check("rst_count", dct_count, 0);
    check("rst_ending", test_ending, 0);
    check("rst_ended", test_has_ended, 0);
    reset = 1'b0;
    #1 check("post_rst_atom_ready", atom_ready, 1);

    // 15 atoms 2'b01, frame_ready held high
    @(negedge clk);
    frame_ready = 1'b1; atom_valid = 1'b1; atom = 2'b01;
    repeat (14) cyc();
    check("f1_not_yet", frame_valid, 0);
    cyc();
    atom_valid = 1'b0;
    check("f1_valid", frame_valid, 1);
    check("f1_buffer", dct_buffer, 30'h15555555);
    check("f1_count", dct_count, 15);
    cyc();
    check("f1_consumed", frame_valid, 0);

    // Backpressure: 15 x 2'b10 then 15 x 2'b11 with the slot blocked
    frame_ready = 1'b0;
    acc_n = 0;
    unstable = 1'b0;
    for (int c = 0; c < 40; c++) begin
      atom_valid = (acc_n < 30);
      atom = (acc_n < 15) ? 2'b10 : 2'b11;
      if (frame_valid && dct_buffer != 30'h2AAAAAAA) unstable = 1'b1;
      if (atom_valid && atom_ready) acc_n++;
      cyc();
    end
    atom_valid = 1'b0;
    check("bp_accepts", acc_n, 30);
    check("bp_stalled", atom_ready, 0);
    check("bp_hold_stable", unstable, 0);
    check("bp_f1_valid", frame_valid, 1);
    check("bp_f1_buffer", dct_buffer, 30'h2AAAAAAA);
    check("bp_f1_count", dct_count, 15);

    // Release: transfer of the full accumulator plus a new atom in the same cycle
    frame_ready = 1'b1; atom_valid = 1'b1; atom = 2'b01;
    #1 check("bp_release_ready", atom_ready, 1);
    cyc();
    check("bp_f2_valid", frame_valid, 1);
    check("bp_f2_buffer", dct_buffer, 30'h3FFFFFFF);
    check("bp_f2_count", dct_count, 15);
    repeat (13) cyc();
    check("restart_not_yet", frame_valid, 0);
    cyc();
    atom_valid = 1'b0;
    check("restart_valid", frame_valid, 1);
    check("restart_buffer", dct_buffer, 30'h15555555);
    check("restart_count", dct_count, 15);
    cyc();
    check("restart_consumed", frame_valid, 0);

    // 11, 00 (no-op), 10 then flush
    atom_valid = 1'b1; atom = 2'b11; cyc();
    atom = 2'b00; cyc();
    atom = 2'b10; cyc();
    atom_valid = 1'b0; flush = 1'b1; cyc();
    flush = 1'b0; frame_ready = 1'b0;
    check("fl_ending", test_ending, 1);
    check("fl_not_ended", test_has_ended, 0);
    cyc();
    check("fl_part_valid", frame_valid, 1);
    check("fl_part_buffer", dct_buffer, 30'h0000000E);
    check("fl_part_count", dct_count, 2);
    cyc();
    check("fl_part_held", dct_buffer, 30'h0000000E);
    check("fl_wait_ended", test_has_ended, 0);
    frame_ready = 1'b1;
    cyc();
    check("fl_ended", test_has_ended, 1);
    check("fl_drained", frame_valid, 0);
    check("fl_no_ready", atom_ready, 0);
    flush = 1'b1; cyc(); flush = 1'b0;
    check("fl_ended_sticky", test_has_ended, 1);

    // Flush with an empty packer
    do_reset();
    flush = 1'b1; cyc(); flush = 1'b0;
    check("ef_ending", test_ending, 1);
    check("ef_not_ended", test_has_ended, 0);
    cyc();
    check("ef_ended", test_has_ended, 1);
    check("ef_no_frame", frame_valid, 0);

    // Flush together with the 15th atom
    do_reset();
    frame_ready = 1'b1; atom_valid = 1'b1; atom = 2'b10;
    repeat (14) cyc();
    flush = 1'b1; cyc();
    flush = 1'b0; atom_valid = 1'b0;
    check("f15_valid", frame_valid, 1);
    check("f15_count", dct_count, 15);
    check("f15_buffer", dct_buffer, 30'h2AAAAAAA);
    check("f15_ending", test_ending, 1);
    cyc();
    check("f15_no_extra", frame_valid, 0);
    check("f15_ended", test_has_ended, 1);
    cyc();
    check("f15_still_none", frame_valid, 0);

    // Reset while draining with a frame pending
    do_reset();
    atom_valid = 1'b1; atom = 2'b01;
    repeat (3) cyc();
    atom_valid = 1'b0; flush = 1'b1; cyc();
    flush = 1'b0; cyc();
    check("dr_pending_valid", frame_valid, 1);
    check("dr_pending_buffer", dct_buffer, 30'h00000015);
    check("dr_pending_count", dct_count, 3);
    reset = 1'b1; cyc();
    check("dr_rst_valid", frame_valid, 0);
    check("dr_rst_buffer", dct_buffer, 0);
    check("dr_rst_count", dct_count, 0);
    check("dr_rst_ending", test_ending, 0);
    check("dr_rst_ended", test_has_ended, 0);
    check("dr_rst_ready", atom_ready, 0);
    reset = 1'b0;
    #1 check("dr_post_rst_ready", atom_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
